// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types and constants for the rounding path
package fpu_pkg;

    // operand bundle handed from a producing unit to the rounder
    typedef struct packed {
        logic        db;
        logic        s;
        logic [12:0] er;
        logic [56:0] fr;
        logic [57:0] flr;
        logic [1:0]  rm;
    } rnd_bundle_t;

    localparam logic [1:0] RM_RNE = 2'd0;
    localparam logic [1:0] RM_RZ  = 2'd1;
    localparam logic [1:0] RM_RPI = 2'd2;
    localparam logic [1:0] RM_RMI = 2'd3;

    // IEEE exception flag positions in IEEEp / sticky_flags
    localparam int FLG_INV = 4;
    localparam int FLG_DBZ = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    // special-case bits in flr
    localparam int FLR_ZERO = 57;
    localparam int FLR_NAN  = 56;
    localparam int FLR_INF  = 55;
    localparam int FLR_INV  = 54;
    localparam int FLR_DBZ  = 53;

endpackage

// File: rtl/rounder.sv
// rtl/rounder.sv - combinational IEEE rounder with overflow/underflow trap wrapping
module rounder
    import fpu_pkg::*;
(
    input  rnd_bundle_t i_b,
    input  logic        i_ovf_en,
    input  logic        i_unf_en,
    output logic [63:0] o_fp,
    output logic [4:0]  o_ieee
);
    logic [52:0]        w_m;
    logic               w_g;
    logic               w_st;
    logic               w_inx;
    logic               w_inc;
    logic [53:0]        w_mr;
    logic               w_carry;
    logic signed [13:0] w_e;
    logic signed [13:0] w_emax;
    logic signed [13:0] w_bias;
    logic signed [13:0] w_ew;
    logic               w_ovf;
    logic               w_unf;
    logic               w_unused;

    // hidden bit sits at fr[55]; fr[56] and the top payload bits are not consumed
    assign w_unused = ^{i_b.fr[56], i_b.flr[52:51], w_ew[13:11], w_mr[52], w_mr[23]};

    // round the significand, then fix up exponent range and pack the result
    always_comb begin
        w_m    = i_b.db ? i_b.fr[55:3] : {29'd0, i_b.fr[55:32]};
        w_g    = i_b.db ? i_b.fr[2]    : i_b.fr[31];
        w_st   = i_b.db ? |i_b.fr[1:0] : |i_b.fr[30:0];
        w_inx  = w_g | w_st;
        w_inc  = 1'b0;
        case (i_b.rm)
            RM_RNE:  w_inc = w_g & (w_st | w_m[0]);
            RM_RZ:   w_inc = 1'b0;
            RM_RPI:  w_inc = ~i_b.s & w_inx;
            RM_RMI:  w_inc = i_b.s & w_inx;
            default: w_inc = 1'b0;
        endcase
        // a carry out leaves the fraction bits all zero, so only the exponent moves
        w_mr    = {1'b0, w_m} + {53'd0, w_inc};
        w_carry = i_b.db ? w_mr[53] : w_mr[24];
        w_e     = $signed({i_b.er[12], i_b.er}) + $signed({13'd0, w_carry});
        w_emax  = i_b.db ? 14'sd2047 : 14'sd255;
        w_bias  = i_b.db ? 14'sd1536 : 14'sd192;
        w_ovf   = (w_e >= w_emax);
        w_unf   = (w_e <= 14'sd0);
        w_ew    = w_ovf ? (w_e - w_bias) : (w_unf ? (w_e + w_bias) : w_e);

        o_fp   = '0;
        o_ieee = '0;
        o_ieee[FLG_INV] = i_b.flr[FLR_INV];
        o_ieee[FLG_DBZ] = i_b.flr[FLR_DBZ];
        if (i_b.flr[FLR_NAN]) begin
            o_fp = i_b.db ? {i_b.s, 11'h7FF, 1'b1, i_b.flr[50:0]}
                          : {32'd0, i_b.s, 8'hFF, 1'b1, i_b.flr[21:0]};
        end else if (i_b.flr[FLR_INF]) begin
            o_fp = i_b.db ? {i_b.s, 11'h7FF, 52'd0} : {32'd0, i_b.s, 8'hFF, 23'd0};
        end else if (i_b.flr[FLR_ZERO]) begin
            o_fp = i_b.db ? {i_b.s, 63'd0} : {32'd0, i_b.s, 31'd0};
        end else if (w_ovf && !i_ovf_en) begin
            o_fp = i_b.db ? {i_b.s, 11'h7FF, 52'd0} : {32'd0, i_b.s, 8'hFF, 23'd0};
            o_ieee[FLG_OVF] = 1'b1;
            o_ieee[FLG_INX] = 1'b1;
        end else if (w_unf && !i_unf_en) begin
            o_fp = i_b.db ? {i_b.s, 63'd0} : {32'd0, i_b.s, 31'd0};
            o_ieee[FLG_UNF] = 1'b1;
            o_ieee[FLG_INX] = 1'b1;
        end else begin
            // in range, or trapped with the exponent wrapped by the bias adjust
            o_fp = i_b.db ? {i_b.s, w_ew[10:0], w_mr[51:0]}
                          : {32'd0, i_b.s, w_ew[7:0], w_mr[22:0]};
            o_ieee[FLG_OVF] = w_ovf;
            o_ieee[FLG_UNF] = w_unf;
            o_ieee[FLG_INX] = w_inx;
        end
    end

endmodule

// File: rtl/rnd_sched.sv
// rtl/rnd_sched.sv - round-robin issue scheduler and two-stage wrapper around the shared rounder
module rnd_sched
    import fpu_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int TAGW = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_db,
    input  logic [NREQ-1:0]       req_s,
    input  logic [NREQ-1:0][12:0] req_er,
    input  logic [NREQ-1:0][56:0] req_fr,
    input  logic [NREQ-1:0][57:0] req_flr,
    input  logic [NREQ-1:0][1:0]  req_rm,
    input  logic                  OVFen,
    input  logic                  UNFen,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [63:0]           out_fp,
    output logic [4:0]            out_ieee,
    output logic [TAGW-1:0]       out_tag,
    input  logic                  clr_flags,
    output logic [4:0]            sticky_flags,
    output logic                  busy
);
    localparam int CW = TAGW + 1;
    localparam logic [CW-1:0] LP_N = CW'(NREQ);

    rnd_bundle_t     r_op;
    logic [TAGW-1:0] r_op_tag;
    logic            r_op_ovf;
    logic            r_op_unf;
    logic            r_op_valid;
    logic [63:0]     r_res_fp;
    logic [4:0]      r_res_ieee;
    logic [TAGW-1:0] r_res_tag;
    logic            r_res_valid;
    logic [TAGW-1:0] r_rr_ptr;
    logic [4:0]      r_sticky;

    logic            w_s1_en;
    logic            w_s0_en;
    logic [NREQ-1:0] w_win;
    logic [TAGW-1:0] w_win_idx;
    logic            w_found;
    logic [CW-1:0]   w_cand;
    logic [TAGW-1:0] w_ptr_nxt;
    logic            w_accept;
    logic            w_hs;
    rnd_bundle_t     w_sel;
    logic [63:0]     w_rnd_fp;
    logic [4:0]      w_rnd_ieee;

    assign w_s1_en   = !(r_res_valid && !out_ready);
    assign w_s0_en   = !r_op_valid || w_s1_en;
    assign req_ready = (rst_n && w_s0_en) ? w_win : '0;
    assign w_accept  = |(req_valid & req_ready);
    assign w_hs      = r_res_valid && out_ready;
    assign w_ptr_nxt = (w_win_idx == TAGW'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;

    // round-robin search starting at r_rr_ptr, wrapping modulo NREQ
    always_comb begin
        w_win     = '0;
        w_win_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + CW'(k);
            if (w_cand >= LP_N) w_cand = w_cand - LP_N;
            if (!w_found && req_valid[w_cand[TAGW-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand[TAGW-1:0];
            end
        end
        if (w_found) w_win[w_win_idx] = 1'b1;
    end

    // gather the winning requester's fields into one bundle
    always_comb begin
        w_sel     = '0;
        w_sel.db  = req_db[w_win_idx];
        w_sel.s   = req_s[w_win_idx];
        w_sel.er  = req_er[w_win_idx];
        w_sel.fr  = req_fr[w_win_idx];
        w_sel.flr = req_flr[w_win_idx];
        w_sel.rm  = req_rm[w_win_idx];
    end

    // S0 operand register, trap enables captured at accept, and the arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_op_tag   <= '0;
            r_op_ovf   <= 1'b0;
            r_op_unf   <= 1'b0;
            r_op_valid <= 1'b0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_s0_en) begin
                r_op_valid <= w_accept;
                if (w_accept) begin
                    r_op     <= w_sel;
                    r_op_tag <= w_win_idx;
                    r_op_ovf <= OVFen;
                    r_op_unf <= UNFen;
                end
            end
            if (w_accept) r_rr_ptr <= w_ptr_nxt;
        end
    end

    rounder u_rounder (
        .i_b      (r_op),
        .i_ovf_en (r_op_ovf),
        .i_unf_en (r_op_unf),
        .o_fp     (w_rnd_fp),
        .o_ieee   (w_rnd_ieee)
    );

    // S1 result register; holds its content while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_fp    <= '0;
            r_res_ieee  <= '0;
            r_res_tag   <= '0;
            r_res_valid <= 1'b0;
        end else if (w_s1_en) begin
            r_res_valid <= r_op_valid;
            if (r_op_valid) begin
                r_res_fp   <= w_rnd_fp;
                r_res_ieee <= w_rnd_ieee;
                r_res_tag  <= r_op_tag;
            end
        end
    end

    // sticky flags: a clear drops history but keeps the result delivered in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (clr_flags) begin
            r_sticky <= w_hs ? r_res_ieee : '0;
        end else if (w_hs) begin
            r_sticky <= r_sticky | r_res_ieee;
        end
    end

    assign out_valid    = r_res_valid;
    assign out_fp       = r_res_fp;
    assign out_ieee     = r_res_ieee;
    assign out_tag      = r_res_tag;
    assign sticky_flags = r_sticky;
    assign busy         = r_op_valid || r_res_valid;

endmodule

// File: tb/tb_rnd_sched.sv
// tb/tb_rnd_sched.sv - scoreboard bench for rnd_sched with a behavioural rounding model
module tb_rnd_sched;

    localparam int F_INV = 4;
    localparam int F_DBZ = 3;
    localparam int F_OVF = 2;
    localparam int F_UNF = 1;
    localparam int F_INX = 0;

    typedef struct packed {
        logic [63:0] fp;
        logic [4:0]  ieee;
    } res_t;

    typedef struct {
        logic [63:0] fp;
        logic [4:0]  ieee;
        int          tag;
        int          acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0]       req_db;
    logic [2:0]       req_s;
    logic [2:0][12:0] req_er;
    logic [2:0][56:0] req_fr;
    logic [2:0][57:0] req_flr;
    logic [2:0][1:0]  req_rm;
    logic             OVFen;
    logic             UNFen;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_fp;
    logic [4:0]       out_ieee;
    logic [1:0]       out_tag;
    logic             clr_flags;
    logic [4:0]       sticky_flags;
    logic             busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   m_ptr   = 0;
    logic [4:0] m_sticky = '0;
    exp_t sb[$];

    rnd_sched #(.NREQ(3), .TAGW(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_db       (req_db),
        .req_s        (req_s),
        .req_er       (req_er),
        .req_fr       (req_fr),
        .req_flr      (req_flr),
        .req_rm       (req_rm),
        .OVFen        (OVFen),
        .UNFen        (UNFen),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_fp       (out_fp),
        .out_ieee     (out_ieee),
        .out_tag      (out_tag),
        .clr_flags    (clr_flags),
        .sticky_flags (sticky_flags),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack(input logic db, input logic s, input int e,
                                         input longint unsigned frac);
        logic [63:0] ev;
        ev = 64'(e);
        if (db) return (64'(s) << 63) | ((ev & 64'h7FF) << 52) | frac;
        return (64'(s) << 31) | ((ev & 64'hFF) << 23) | frac;
    endfunction

    // value-level rounding: keep/remainder split compared against one half ulp
    function automatic res_t ref_round(input logic db, input logic s, input logic [12:0] er,
                                       input logic [56:0] fr, input logic [57:0] flr,
                                       input logic [1:0] rm, input logic ovfen, input logic unfen);
        res_t r;
        int fbits, drop, emax, bias, e;
        longint unsigned keep, rem, half, frac;
        bit inx, inc;
        fbits = db ? 52 : 23;
        drop  = db ? 3 : 32;
        emax  = db ? 2047 : 255;
        bias  = db ? 1536 : 192;
        r.fp  = '0;
        r.ieee = '0;
        r.ieee[F_INV] = flr[54];
        r.ieee[F_DBZ] = flr[53];
        if (flr[56]) begin
            r.fp = pack(db, s, emax, (64'd1 << (fbits - 1)) |
                        (64'(flr[52:0]) & ((64'd1 << (fbits - 1)) - 1)));
        end else if (flr[55]) begin
            r.fp = pack(db, s, emax, 0);
        end else if (flr[57]) begin
            r.fp = pack(db, s, 0, 0);
        end else begin
            keep = 64'(fr[55:0]) >> drop;
            rem  = 64'(fr[55:0]) & ((64'd1 << drop) - 1);
            half = 64'd1 << (drop - 1);
            inx  = (rem != 0);
            case (rm)
                2'd0:    inc = (rem > half) || (rem == half && keep[0]);
                2'd1:    inc = 1'b0;
                2'd2:    inc = inx && !s;
                default: inc = inx && s;
            endcase
            keep = keep + 64'(inc);
            e = int'($signed(er));
            if (keep >= (64'd1 << (fbits + 1))) e++;
            frac = keep & ((64'd1 << fbits) - 1);
            if (e >= emax) begin
                r.ieee[F_OVF] = 1'b1;
                if (ovfen) begin
                    r.fp = pack(db, s, e - bias, frac);
                    r.ieee[F_INX] = inx;
                end else begin
                    r.fp = pack(db, s, emax, 0);
                    r.ieee[F_INX] = 1'b1;
                end
            end else if (e <= 0) begin
                r.ieee[F_UNF] = 1'b1;
                if (unfen) begin
                    r.fp = pack(db, s, e + bias, frac);
                    r.ieee[F_INX] = inx;
                end else begin
                    r.fp = pack(db, s, 0, 0);
                    r.ieee[F_INX] = 1'b1;
                end
            end else begin
                r.fp = pack(db, s, e, frac);
                r.ieee[F_INX] = inx;
            end
        end
        return r;
    endfunction

    task automatic set_req(input int i, input logic db, input logic s, input logic [12:0] er,
                           input logic [56:0] fr, input logic [57:0] flr, input logic [1:0] rm);
        req_db[i]  = db;
        req_s[i]   = s;
        req_er[i]  = er;
        req_fr[i]  = fr;
        req_flr[i] = flr;
        req_rm[i]  = rm;
    endtask

    task automatic rand_req(input int i);
        logic [63:0] t;
        logic [56:0] fr;
        logic [57:0] flr;
        logic [12:0] er;
        logic        db;
        db = 1'($urandom);
        t  = {$urandom, $urandom};
        fr = t[56:0];
        fr[55] = 1'b1;
        if ($urandom % 8 == 0) fr[55:0] = '1;
        case ($urandom % 4)
            0:       er = 13'($urandom_range(0, 6) - 3);
            1:       er = 13'((db ? 2047 : 255) - 2 + $urandom_range(0, 3));
            default: er = 13'($urandom_range(1, db ? 2046 : 254));
        endcase
        t   = {$urandom, $urandom};
        flr = '0;
        flr[52:0] = t[52:0];
        if ($urandom % 6 == 0) flr[57:53] = 5'($urandom);
        set_req(i, db, 1'($urandom), er, fr, flr, 2'($urandom));
    endtask

    // predict the grant from the model, compare, and queue the expected result
    task automatic drive_check();
        int w;
        logic [2:0] exp_rdy;
        res_t r;
        #1;
        w = -1;
        if (rst_n && !(sb.size() == 2 && !out_ready)) begin
            for (int k = 0; k < 3; k++) begin
                int j;
                j = (m_ptr + k) % 3;
                if (w < 0 && req_valid[j]) w = j;
            end
        end
        exp_rdy = (w >= 0) ? 3'(1 << w) : 3'd0;
        chk("req_ready", req_ready, exp_rdy);
        if (w >= 0) begin
            r = ref_round(req_db[w], req_s[w], req_er[w], req_fr[w], req_flr[w], req_rm[w],
                          OVFen, UNFen);
            sb.push_back('{fp: r.fp, ieee: r.ieee, tag: w, acc: cyc});
            m_ptr = (w + 1) % 3;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = '0;
            clr_flags = 1'b0;
            drive_check();
        end
    endtask

    // monitor: compares the presented output against the oldest expected entry
    always @(negedge clk) begin
        bit   exp_v;
        int   nb;
        logic [4:0] hsv;
        #2;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_sticky", sticky_flags, 0);
            chk("rst_out_fp", out_fp, 0);
            chk("rst_out_tag", out_tag, 0);
            m_sticky = '0;
        end else begin
            exp_v = (sb.size() > 0) && (sb[0].acc <= cyc - 2);
            nb = 0;
            foreach (sb[q]) if (sb[q].acc < cyc) nb++;
            chk("out_valid", out_valid, exp_v);
            chk("busy", busy, nb > 0);
            chk("sticky", sticky_flags, m_sticky);
            hsv = '0;
            if (exp_v) begin
                chk("out_fp", out_fp, sb[0].fp);
                chk("out_ieee", out_ieee, sb[0].ieee);
                chk("out_tag", out_tag, sb[0].tag);
                if (out_ready) begin
                    hsv = sb[0].ieee;
                    void'(sb.pop_front());
                end
            end
            m_sticky = clr_flags ? hsv : (m_sticky | hsv);
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_db = '0; req_s = '0; req_er = '0; req_fr = '0; req_flr = '0; req_rm = '0;
        OVFen = 1'b0; UNFen = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
        repeat (3) begin
            @(negedge clk);
            drive_check();
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_check();

        // fairness: all requesters busy, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_req(i);
            req_flr[i] = '0;
        end
        repeat (6) begin
            @(negedge clk);
            req_valid = 3'b111;
            drive_check();
        end
        idle(3);

        // single op: requester 1, double, positive zero
        @(negedge clk);
        set_req(1, 1'b1, 1'b0, 13'd1023, 57'h0, 58'h1 << 57, 2'd0);
        req_valid = 3'b010;
        drive_check();
        idle(3);

        // back-pressure: three requests, consumer stalled for five cycles
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) rand_req(i);
            req_valid = 3'b111;
            drive_check();
        end
        idle(2);
        out_ready = 1'b1;
        idle(4);

        // sticky flags: DBZ then INV, then clear alongside a flag-free handshake
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 13'd1023, 57'h0, (58'h1 << 55) | (58'h1 << 53), 2'd0);
        req_valid = 3'b001;
        drive_check();
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 13'd1023, 57'h0, (58'h1 << 56) | (58'h1 << 54) | 58'h5, 2'd0);
        req_valid = 3'b001;
        drive_check();
        idle(3);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 13'd0, 57'h0, 58'h1 << 57, 2'd0);
        req_valid = 3'b001;
        drive_check();
        idle(1);
        @(negedge clk);
        clr_flags = 1'b1;
        req_valid = '0;
        drive_check();
        idle(2);

        // trap enable must be the value seen at accept
        @(negedge clk);
        OVFen = 1'b1;
        set_req(2, 1'b1, 1'b0, 13'd2047, 57'h0A5_5A5A_5A5A_5A5A << 0 | (57'h1 << 55), 58'h0, 2'd0);
        req_valid = 3'b100;
        drive_check();
        @(negedge clk);
        OVFen = 1'b0;
        req_valid = '0;
        drive_check();
        idle(3);

        // reset with both stages full
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) rand_req(i);
            req_valid = 3'b111;
            drive_check();
        end
        idle(1);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        m_ptr = 0;
        drive_check();
        @(negedge clk);
        drive_check();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        req_valid = 3'b111;
        drive_check();
        idle(3);

        // randomized traffic
        repeat (1500) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) rand_req(i);
            req_valid = 3'($urandom);
            out_ready = ($urandom % 4) != 0;
            clr_flags = ($urandom % 16) == 0;
            OVFen = 1'($urandom);
            UNFen = 1'($urandom);
            drive_check();
        end

        out_ready = 1'b1;
        idle(5);
        chk("drain_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
